// File: rtl/axi4_full_master_rw_v4_pkg.sv
// Shared definitions for the axi4_full_master_rw_v4 master and its burst checker.
// Holds the FSM state encodings, the error flag bit indices, the AXI
// BURST/RESP/CACHE constants and the AxSIZE helper.
package axi4_full_master_rw_v4_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_END  = 2'd3
    } rd_state_t;

    localparam int ERR_BRESP  = 0;
    localparam int ERR_RRESP  = 1;
    localparam int ERR_RLAST  = 2;
    localparam int ERR_REJECT = 3;

    localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
    localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0010;
    // SLVERR and DECERR both have bit 1 set; that bit alone flags a bad response.
    localparam int         AXI_RESP_ERR_BIT     = 1;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi4_full_master_rw_v4_burst_check.sv
// Combinational command legality check for one burst engine.
//   i_addr_lo : low 12 bits of the user byte address
//   i_len     : burst length minus one
//   o_ok      : address aligned to the beat size, burst not longer than
//               MAX_BURST_LEN, and burst stays inside its 4 KB page
module axi4_full_master_rw_v4_burst_check
    import axi4_full_master_rw_v4_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic [11:0] i_addr_lo,
    input  logic [7:0]  i_len,
    output logic        o_ok
);
    localparam int SIZE_LOG2 = int'(axi_size(DATA_WIDTH));

    logic [12:0] w_beats;
    logic [12:0] w_bytes;
    logic [12:0] w_end;
    logic        w_aligned;
    logic        w_len_ok;
    logic        w_in_page;

    // 13 bits covers 4095 + 256 beats * 16 bytes without overflow.
    assign w_beats   = {5'd0, i_len} + 13'd1;
    assign w_bytes   = w_beats << SIZE_LOG2;
    assign w_end     = {1'b0, i_addr_lo} + w_bytes;
    assign w_aligned = (i_addr_lo[SIZE_LOG2-1:0] == '0);
    assign w_len_ok  = (w_beats <= 13'(MAX_BURST_LEN));
    assign w_in_page = (w_end <= 13'd4096);
    assign o_ok      = w_aligned && w_len_ok && w_in_page;

endmodule

// File: rtl/axi4_full_master_rw_v4.sv
// AXI4-full master with independent write and read burst engines behind a
// start/valid/ready user interface.
//   user write : write_address/len/start, write_data/_valid -> write_ready,
//                write_data_last, write_end, write_busy
//   user read  : read_address/len/start, read_ready -> read_data/_valid/_last,
//                read_end, read_busy
//   status     : output_idle, error_flags (sticky, error_clear), output_error
//   AXI        : full AW/W/B/AR/R master channels
//
// state  | meaning
// W_IDLE | write engine free, accepts write_start
// W_ADDR | AWVALID held until AWREADY
// W_DATA | streaming beats, WLAST on count == len
// W_RESP | BREADY high, waiting for BVALID
// R_IDLE | read engine free, accepts read_start
// R_ADDR | ARVALID held until ARREADY
// R_DATA | RREADY follows read_ready until RLAST handshake
// R_END  | read_end pulse
module axi4_full_master_rw_v4
    import axi4_full_master_rw_v4_pkg::*;
#(
    parameter int                          C_M_AXI_ADDR_WIDTH         = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
    parameter int                          C_M_AXI_MAX_BURST_LEN      = 256,
    parameter int                          C_M_AXI_ID_WIDTH           = 1,
    parameter int                          C_M_AXI_DATA_WIDTH         = 32,
    parameter int                          C_M_AXI_AWUSER_WIDTH       = 1,
    parameter int                          C_M_AXI_ARUSER_WIDTH       = 1,
    parameter int                          C_M_AXI_WUSER_WIDTH        = 1,
    parameter int                          C_M_AXI_RUSER_WIDTH        = 1,
    parameter int                          C_M_AXI_BUSER_WIDTH        = 1
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   write_address,
    input  logic [7:0]                      write_len,
    input  logic                            write_start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   write_data,
    input  logic                            write_data_valid,
    output logic                            write_ready,
    output logic                            write_data_last,
    output logic                            write_end,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   read_address,
    input  logic [7:0]                      read_len,
    input  logic                            read_start,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   read_data,
    output logic                            read_data_valid,
    output logic                            read_data_last,
    input  logic                            read_ready,
    output logic                            read_end,
    output logic                            write_busy,
    output logic                            read_busy,
    output logic                            output_idle,
    input  logic                            error_clear,
    output logic [3:0]                      error_flags,
    output logic                            output_error,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0] M_AXI_AWUSER,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]  M_AXI_WUSER,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]  M_AXI_BUSER,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0] M_AXI_ARUSER,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]  M_AXI_RUSER,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    wr_state_t                       r_wstate, w_wnext;
    rd_state_t                       r_rstate, w_rnext;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_waddr, r_raddr;
    logic [7:0]                      r_wlen, r_rlen;
    logic [7:0]                      r_wcnt, r_rcnt;
    logic [3:0]                      r_err_flags;
    logic [3:0]                      w_err_set;
    logic                            w_wcmd_ok, w_rcmd_ok;
    logic                            w_wbeat, w_rbeat;
    logic                            w_wlast, w_rlast;
    logic                            w_unused;

    axi4_full_master_rw_v4_burst_check #(
        .DATA_WIDTH    (C_M_AXI_DATA_WIDTH),
        .MAX_BURST_LEN (C_M_AXI_MAX_BURST_LEN)
    ) u_wr_check (
        .i_addr_lo (write_address[11:0]),
        .i_len     (write_len),
        .o_ok      (w_wcmd_ok)
    );

    axi4_full_master_rw_v4_burst_check #(
        .DATA_WIDTH    (C_M_AXI_DATA_WIDTH),
        .MAX_BURST_LEN (C_M_AXI_MAX_BURST_LEN)
    ) u_rd_check (
        .i_addr_lo (read_address[11:0]),
        .i_len     (read_len),
        .o_ok      (w_rcmd_ok)
    );

    assign w_wbeat = M_AXI_WVALID && M_AXI_WREADY;
    assign w_rbeat = M_AXI_RVALID && M_AXI_RREADY;
    assign w_wlast = (r_wcnt == r_wlen);
    assign w_rlast = (r_rcnt == r_rlen);

    always_comb begin
        w_wnext   = r_wstate;
        w_rnext   = r_rstate;
        w_err_set = '0;
        case (r_wstate)
            W_IDLE: if (write_start) begin
                if (w_wcmd_ok) w_wnext = W_ADDR;
                else           w_err_set[ERR_REJECT] = 1'b1;
            end
            W_ADDR: if (M_AXI_AWREADY) w_wnext = W_DATA;
            W_DATA: if (w_wbeat && w_wlast) w_wnext = W_RESP;
            W_RESP: if (M_AXI_BVALID) begin
                w_wnext = W_IDLE;
                w_err_set[ERR_BRESP] = M_AXI_BRESP[AXI_RESP_ERR_BIT];
            end
            default: w_wnext = W_IDLE;
        endcase
        case (r_rstate)
            R_IDLE: if (read_start) begin
                if (w_rcmd_ok) w_rnext = R_ADDR;
                else           w_err_set[ERR_REJECT] = 1'b1;
            end
            R_ADDR: if (M_AXI_ARREADY) w_rnext = R_DATA;
            R_DATA: if (w_rbeat) begin
                w_err_set[ERR_RRESP] = M_AXI_RRESP[AXI_RESP_ERR_BIT];
                // Early RLAST and missing RLAST on the expected last beat both count.
                w_err_set[ERR_RLAST] = (M_AXI_RLAST != w_rlast);
                if (M_AXI_RLAST) w_rnext = R_END;
            end
            R_END:   w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_wstate    <= W_IDLE;
            r_rstate    <= R_IDLE;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_wlen      <= '0;
            r_rlen      <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_err_flags <= '0;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
            if (r_wstate == W_IDLE && write_start && w_wcmd_ok) begin
                r_waddr <= write_address;
                r_wlen  <= write_len;
            end
            if (r_rstate == R_IDLE && read_start && w_rcmd_ok) begin
                r_raddr <= read_address;
                r_rlen  <= read_len;
            end
            if (r_wstate == W_ADDR)      r_wcnt <= '0;
            else if (w_wbeat)            r_wcnt <= r_wcnt + 8'd1;
            if (r_rstate == R_ADDR)      r_rcnt <= '0;
            else if (w_rbeat)            r_rcnt <= r_rcnt + 8'd1;
            // A new error in the same cycle as error_clear survives the clear.
            r_err_flags <= (error_clear ? 4'b0000 : r_err_flags) | w_err_set;
        end
    end

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = C_M_TARGET_SLAVE_BASE_ADDR + r_waddr;
    assign M_AXI_AWLEN   = r_wlen;
    assign M_AXI_AWSIZE  = axi_size(C_M_AXI_DATA_WIDTH);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = AXI_CACHE_MODIFIABLE;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWUSER  = C_M_AXI_AWUSER_WIDTH'(1);
    assign M_AXI_AWVALID = (r_wstate == W_ADDR);
    assign M_AXI_WDATA   = write_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (r_wstate == W_DATA) && w_wlast;
    assign M_AXI_WUSER   = '0;
    assign M_AXI_WVALID  = (r_wstate == W_DATA) && write_data_valid;
    assign M_AXI_BREADY  = (r_wstate == W_RESP);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = C_M_TARGET_SLAVE_BASE_ADDR + r_raddr;
    assign M_AXI_ARLEN   = r_rlen;
    assign M_AXI_ARSIZE  = axi_size(C_M_AXI_DATA_WIDTH);
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = AXI_CACHE_MODIFIABLE;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARUSER  = C_M_AXI_ARUSER_WIDTH'(1);
    assign M_AXI_ARVALID = (r_rstate == R_ADDR);
    assign M_AXI_RREADY  = (r_rstate == R_DATA) && read_ready;

    assign write_ready     = (r_wstate == W_DATA) && M_AXI_WREADY;
    assign write_data_last = (r_wstate == W_DATA) && w_wlast;
    assign write_end       = (r_wstate == W_RESP) && M_AXI_BVALID;
    assign read_data       = M_AXI_RDATA;
    assign read_data_valid = (r_rstate == R_DATA) && M_AXI_RVALID;
    assign read_data_last  = (r_rstate == R_DATA) && M_AXI_RLAST;
    assign read_end        = (r_rstate == R_END);
    assign write_busy      = (r_wstate != W_IDLE);
    assign read_busy       = (r_rstate != R_IDLE);
    assign output_idle     = !write_busy && !read_busy;
    assign error_flags     = r_err_flags;
    assign output_error    = |r_err_flags;

    assign w_unused = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_BRESP[0],
                        M_AXI_RID, M_AXI_RUSER, M_AXI_RRESP[0]};

endmodule

// File: tb/tb_axi4_full_master_rw_v4.sv
module tb_axi4_full_master_rw_v4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        M_AXI_ARESETN;
    logic [31:0] write_address, read_address, write_data, read_data;
    logic [7:0]  write_len, read_len;
    logic        write_start, write_data_valid, write_ready, write_data_last, write_end;
    logic        read_start, read_data_valid, read_data_last, read_ready, read_end;
    logic        write_busy, read_busy, output_idle, error_clear, output_error;
    logic [3:0]  error_flags;
    logic [0:0]  M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
    logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWLOCK, M_AXI_ARLOCK;
    logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS, M_AXI_WSTRB;
    logic [0:0]  M_AXI_AWUSER, M_AXI_ARUSER, M_AXI_WUSER, M_AXI_BUSER, M_AXI_RUSER;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    int n_assert = 0;
    int n_fail   = 0;

    axi4_full_master_rw_v4 dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(M_AXI_ARESETN),
        .write_address(write_address), .write_len(write_len), .write_start(write_start),
        .write_data(write_data), .write_data_valid(write_data_valid),
        .write_ready(write_ready), .write_data_last(write_data_last), .write_end(write_end),
        .read_address(read_address), .read_len(read_len), .read_start(read_start),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .read_data_last(read_data_last), .read_ready(read_ready), .read_end(read_end),
        .write_busy(write_busy), .read_busy(read_busy), .output_idle(output_idle),
        .error_clear(error_clear), .error_flags(error_flags), .output_error(output_error),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags(input string tag);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        #1;
        chk({tag, " cleared"}, 32'(error_flags), 32'd0);
    endtask

    // Runs up to one write and one read against an always-ready slave for
    // ncyc cycles starting with the start strobes at cycle 0. Write-side
    // control timing is checked cycle by cycle; read data is checked in order.
    task automatic run_burst(input string tag,
                             input bit do_wr, input logic [31:0] waddr,
                             input logic [7:0] wlen, input logic [1:0] bresp,
                             input bit do_rd, input logic [31:0] raddr,
                             input logic [7:0] rlen, input int rlast_at,
                             input bit rr_toggle, input int rst_at, input int ncyc,
                             input logic [3:0] exp_flags);
        int   wbeat, sidx, rx, ends, wl;
        bit   wl_seen, rdone, live;
        logic [5:0] exp_v;
        wbeat = 0; sidx = 0; rx = 0; ends = 0; wl = int'(wlen);
        wl_seen = 1'b0; rdone = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            live             = (rst_at < 0) || (c <= rst_at);
            M_AXI_ARESETN    = (c == rst_at) ? 1'b0 : 1'b1;
            write_start      = do_wr && (c == 0);
            write_address    = waddr;
            write_len        = wlen;
            read_start       = do_rd && (c == 0);
            read_address     = raddr;
            read_len         = rlen;
            write_data_valid = 1'b1;
            write_data       = 32'hA000_0000 + 32'(wbeat);
            M_AXI_AWREADY    = 1'b1;
            M_AXI_WREADY     = 1'b1;
            M_AXI_ARREADY    = 1'b1;
            M_AXI_BVALID     = wl_seen;
            M_AXI_BRESP      = bresp;
            read_ready       = rr_toggle ? c[0] : 1'b1;
            M_AXI_RVALID     = do_rd && (c >= 2) && !rdone;
            M_AXI_RDATA      = 32'h5A00_0000 + 32'(sidx);
            M_AXI_RLAST      = (sidx == rlast_at);
            M_AXI_RRESP      = 2'b00;
            #1;
            exp_v = '0;
            if (live) begin
                if (do_wr) begin
                    exp_v[5] = (c == 1);
                    exp_v[4] = (c >= 2) && (c <= wl + 2);
                    exp_v[3] = (c == wl + 2);
                    exp_v[2] = (c == wl + 3);
                    exp_v[1] = (c == wl + 3);
                end
                if (do_rd) exp_v[0] = (c == 1);
            end
            chk($sformatf("%s ctl c%0d", tag, c),
                32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, write_end, M_AXI_ARVALID}),
                32'(exp_v));
            if (exp_v[5]) begin
                chk({tag, " awaddr"}, M_AXI_AWADDR, waddr);
                chk({tag, " awlen"}, 32'(M_AXI_AWLEN), 32'(wlen));
            end
            if (exp_v[4]) chk($sformatf("%s wdata c%0d", tag, c), M_AXI_WDATA, 32'hA000_0000 + 32'(c - 2));
            if (exp_v[0]) begin
                chk({tag, " araddr"}, M_AXI_ARADDR, raddr);
                chk({tag, " arlen"}, 32'(M_AXI_ARLEN), 32'(rlen));
                chk({tag, " arsize"}, 32'(M_AXI_ARSIZE), 32'd2);
            end
            if (!live) chk($sformatf("%s idle after reset c%0d", tag, c), 32'(output_idle), 32'd1);
            if (read_end) ends++;
            if (read_data_valid && read_ready) begin
                chk($sformatf("%s rdata %0d", tag, rx), read_data, 32'h5A00_0000 + 32'(rx));
                chk($sformatf("%s rlast %0d", tag, rx), 32'(read_data_last), 32'(rx == rlast_at));
                rx++;
            end
            if (M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST) wl_seen = 1'b1;
            if (M_AXI_BVALID && M_AXI_BREADY) wl_seen = 1'b0;
            if (write_ready) wbeat++;
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                if (M_AXI_RLAST) rdone = 1'b1;
                sidx++;
            end
            step();
        end
        M_AXI_ARESETN = 1'b1;
        write_start   = 1'b0;
        read_start    = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_RVALID  = 1'b0;
        #1;
        chk({tag, " beats"}, 32'(rx), do_rd ? 32'(rlast_at + 1) : 32'd0);
        chk({tag, " read_end count"}, 32'(ends), do_rd ? 32'd1 : 32'd0);
        chk({tag, " flags"}, 32'(error_flags), 32'(exp_flags));
        chk({tag, " output_error"}, 32'(output_error), 32'(|exp_flags));
        chk({tag, " idle at end"}, 32'(output_idle), 32'd1);
    endtask

    initial begin
        M_AXI_ARESETN = 1'b0;
        write_address = '0; write_len = '0; write_start = 1'b0;
        write_data = '0; write_data_valid = 1'b0;
        read_address = '0; read_len = '0; read_start = 1'b0; read_ready = 1'b0;
        error_clear = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BID = '0; M_AXI_BRESP = '0; M_AXI_BUSER = '0; M_AXI_BVALID = 1'b0;
        M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 1'b0;
        M_AXI_RUSER = '0; M_AXI_RVALID = 1'b0;

        repeat (3) step();
        chk("reset ctl", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        chk("reset ends", 32'({write_end, read_end}), 32'd0);
        chk("reset busy", 32'({write_busy, read_busy}), 32'd0);
        chk("reset idle", 32'(output_idle), 32'd1);
        chk("reset flags", 32'(error_flags), 32'd0);
        M_AXI_ARESETN = 1'b1;
        step();

        run_burst("wr_len3", 1'b1, 32'h0000_1000, 8'd3, 2'b00,
                  1'b0, 32'h0, 8'd0, 0, 1'b0, -1, 10, 4'b0000);

        run_burst("rd_len255", 1'b0, 32'h0, 8'd0, 2'b00,
                  1'b1, 32'h0000_0000, 8'd255, 255, 1'b1, -1, 530, 4'b0000);

        // 0xFC0 + 32 beats * 4 bytes = 0x1040: crosses the 4 KB page.
        write_address = 32'h0000_0FC0;
        write_len     = 8'd31;
        write_start   = 1'b1;
        step();
        write_start = 1'b0;
        #1;
        chk("rej4k awvalid", 32'(M_AXI_AWVALID), 32'd0);
        chk("rej4k busy", 32'(write_busy), 32'd0);
        chk("rej4k flags", 32'(error_flags), 32'h8);
        chk("rej4k output_error", 32'(output_error), 32'd1);
        step();
        chk("rej4k awvalid later", 32'(M_AXI_AWVALID), 32'd0);
        chk("rej4k no write_end", 32'(write_end), 32'd0);
        clear_flags("rej4k");
        chk("rej4k output_error cleared", 32'(output_error), 32'd0);

        // Misaligned read rejected in the same cycle as error_clear: set wins.
        read_address = 32'h0000_0002;
        read_len     = 8'd0;
        read_start   = 1'b1;
        error_clear  = 1'b1;
        step();
        read_start  = 1'b0;
        error_clear = 1'b0;
        #1;
        chk("rej_align flags", 32'(error_flags), 32'h8);
        chk("rej_align arvalid", 32'(M_AXI_ARVALID), 32'd0);
        chk("rej_align busy", 32'(read_busy), 32'd0);
        clear_flags("rej_align");

        // 0xF80 + 128 bytes lands exactly on 0x1000: still legal.
        run_burst("wr_4k_edge", 1'b1, 32'h0000_0F80, 8'd31, 2'b00,
                  1'b0, 32'h0, 8'd0, 0, 1'b0, -1, 38, 4'b0000);

        run_burst("rd_early_rlast", 1'b0, 32'h0, 8'd0, 2'b00,
                  1'b1, 32'h0000_2000, 8'd7, 2, 1'b0, -1, 14, 4'b0100);
        clear_flags("rd_early_rlast");

        run_burst("wr_rd_conc", 1'b1, 32'h0000_3000, 8'd15, 2'b10,
                  1'b1, 32'h0000_4000, 8'd15, 15, 1'b0, -1, 22, 4'b0001);
        clear_flags("wr_rd_conc");

        run_burst("wr_reset", 1'b1, 32'h0000_5000, 8'd15, 2'b00,
                  1'b0, 32'h0, 8'd0, 0, 1'b0, 6, 14, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
